// File: rtl/delay_line_checker_pkg.sv
// Shared definitions for the delay-line checker: FSM state encoding,
// LFSR feedback taps and the default LFSR seed.
package delay_line_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7, 5, 4, 3 of a left-shifting register
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/dlc_lfsr.sv
// 8-bit Fibonacci LFSR used as the stimulus source of the delay-line checker.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset (register returns to SEED)
//   load    load the register from seed (has priority over advance)
//   advance shift the register left by one with XOR feedback into bit 0
//   seed    value loaded on load
//   msb     current register MSB (the serial output bit)
module dlc_lfsr
    import delay_line_checker_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic       msb
);

    logic [7:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

    assign msb = q[7];

endmodule

// File: rtl/delay_line_checker.sv
// Built-in self test for a serial delay path: emits an LFSR bit stream on
// stim_out, compares resp_in against the same stream delayed by LATENCY
// cycles (optionally inverted) and reports mismatch statistics.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, length   run request (accepted in IDLE) and number of bits
//   stim_out        serial stimulus, 0 outside RUN
//   resp_in         serial response from the path under test
//   busy            high in RUN and DRAIN
//   done            one-cycle completion pulse
//   pass            no mismatches in the last completed run
//   err_count       saturating mismatch count
//   first_err_idx   bit index of the first mismatch, all-ones if none
module delay_line_checker
    import delay_line_checker_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter bit          INVERT  = 1'b0,
    parameter int unsigned CNT_W   = 16,
    parameter logic [7:0]  SEED    = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    output logic             stim_out,
    input  logic             resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               lfsr_msb;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cmp_idx;
    logic [CNT_W-1:0]   err_next;
    logic [LATENCY-1:0] exp_bit;
    logic [LATENCY-1:0] exp_vld;
    logic               mismatch;

    dlc_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (state == RUN),
        .seed    (SEED),
        .msb     (lfsr_msb)
    );

    assign stim_out = (state == RUN) & lfsr_msb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the remaining cycles of the current phase; it is reloaded
    // with LATENCY on the RUN->DRAIN edge so one counter serves both phases.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Expected-value pipeline: bit k enters at the edge ending cycle k and
    // reaches the last stage in time for the edge ending cycle k+LATENCY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_vld <= '0;
            exp_bit <= '0;
        end else begin
            exp_vld[0] <= (state == RUN);
            exp_bit[0] <= stim_out;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                exp_vld[i] <= exp_vld[i-1];
                exp_bit[i] <= exp_bit[i-1];
            end
        end
    end

    assign mismatch = exp_vld[LATENCY-1] &&
                      (resp_in != (exp_bit[LATENCY-1] ^ INVERT));

    always_comb begin
        err_next = err_count;
        if (accept) begin
            err_next = '0;
        end else if (mismatch && (err_count != '1)) begin
            err_next = err_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            cmp_idx       <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
            pass          <= 1'b0;
        end else begin
            err_count <= err_next;
            if (accept) begin
                cnt           <= length;
                cmp_idx       <= '0;
                first_err_idx <= '1;
            end else begin
                if (state == RUN && state_nxt == DRAIN) begin
                    cnt <= LAT_CNT;
                end else if (busy) begin
                    cnt <= cnt - CNT_ONE;
                end
                if (exp_vld[LATENCY-1]) begin
                    cmp_idx <= cmp_idx + CNT_ONE;
                end
                if (mismatch && (err_count == '0)) begin
                    first_err_idx <= cmp_idx;
                end
            end
            // pass is settled on entry to DONE so it is valid alongside done
            if (state_nxt == DONE) begin
                pass <= (err_next == '0);
            end else if (accept) begin
                pass <= 1'b0;
            end
        end
    end

endmodule

// File: doc/delay_line_checker.md
DELAY_LINE_CHECKER -- requirements
Module: delay_line_checker

Interface
REQ-001 Parameter LATENCY, default 3, is the clock cycles from stim_out to the matching resp_in sample (1..15).
REQ-002 Parameter INVERT, default 0, means expected response = stimulus XOR INVERT.
REQ-003 Parameter CNT_W, default 16, is the width of length, err_count and first_err_idx.
REQ-004 Parameter SEED, default 8'hA5, is the nonzero LFSR seed.
REQ-005 Reset is rst, asynchronous, active-low; the clock is clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  run request, sampled in IDLE only.
REQ-009 length  input  CNT_W  number of stimulus bits, captured on start acceptance.
REQ-010 stim_out  output  1  serial stimulus to the delay path under test.
REQ-011 resp_in  input  1  serial response from the delay path under test.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse in DONE.
REQ-014 pass  output  1  err_count==0 for the last completed run; held until the next start.
REQ-015 err_count  output  CNT_W  mismatches in the last or current run, saturating.
REQ-016 first_err_idx  output  CNT_W  index of the first mismatching bit; all-ones if none.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, with transitions IDLE->RUN->DRAIN->DONE->IDLE.
REQ-018 In IDLE, start=1 SHALL be accepted: capture length, load the LFSR with SEED, clear err_count, set first_err_idx to all-ones, and enter RUN (or DONE if length==0).
REQ-019 The LFSR SHALL be an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left, with stim_out = MSB.
REQ-020 Bit k (k=0..length-1) SHALL drive stim_out during the k-th cycle after acceptance, and the LFSR SHALL advance once per RUN cycle.
REQ-021 RUN SHALL last exactly length cycles; stim_out SHALL be 0 outside RUN.
REQ-022 Each emitted bit and a valid flag SHALL enter a LATENCY-deep expected-value pipeline.
REQ-023 Bit k SHALL be compared with resp_in at the rising edge that ends cycle k+LATENCY.
REQ-024 A mismatch SHALL occur when resp_in != (bit XOR INVERT) and the pipeline valid flag is set.
REQ-025 On each mismatch, err_count SHALL increment, saturating at all-ones.
REQ-026 On the first mismatch, first_err_idx SHALL capture k.
REQ-027 DRAIN SHALL last exactly LATENCY cycles so that every bit is compared, then enter DONE.
REQ-028 DONE SHALL last one cycle: done=1, pass updated, then return to IDLE.
REQ-029 start while busy or in DONE SHALL be ignored, and length changes SHALL have no effect after capture.
REQ-030 length==0 SHALL give done one cycle after acceptance, with pass=1 and err_count=0.
REQ-031 Total latency from the accepting edge to done high SHALL be length+LATENCY+1 cycles.

Reset
REQ-032 Asserting rst SHALL immediately force the FSM to IDLE, the LFSR to SEED, and the pipeline valid flags to 0.
REQ-033 Asserting rst SHALL force stim_out=0, busy=0, done=0, pass=0, err_count=0 and first_err_idx to all-ones.
REQ-034 Reset mid-run SHALL abandon the run with no done pulse; the next start SHALL begin a fresh run.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the LFSR tap constant and the default SEED.
REQ-036 The LFSR SHALL be one sub-module, dlc_lfsr, with ports clk, rst, load, advance, seed and msb.
REQ-037 All other logic, including the pipeline, counters and FSM, SHALL be in delay_line_checker.

Verification
REQ-038 Loopback through a 3-flop behavioural delay, LATENCY=3, length=100: done at cycle 104, pass=1, err_count=0, first_err_idx=16'hFFFF.
REQ-039 Same setup with resp_in forced inverted for bit 10 only: err_count=1, first_err_idx=10, pass=0.
REQ-040 A 2-flop delay with LATENCY=3, length=64: err_count>0 and pass=0; INVERT=1 with a non-inverting path: err_count=64.
REQ-041 length=0: done one cycle after start, pass=1, and stim_out stays 0.
REQ-042 rst asserted at cycle 20 of a length=50 run: outputs at reset values, no done; a following length=10 run passes.
REQ-043 start pulsed during RUN: ignored, and the original run completes with its captured length.
